puncturer: RTL and testbench
============================

# puncturer

Rate-adaptation stage directly downstream of the convolutional encoder: consumes rate-1/2 coded beats (2*WIDTH bits), deletes coded bits per the frame's selected code rate (1/2, 2/3, 3/4), and repacks surviving bits into full 2*WIDTH-bit output words. Each frame ends with a zero-padded final word carrying tlast. The AXI-Stream in/out feeds the interleaver stage.

## Interface
- WIDTH, 24, input information bits per encoder beat; must be a multiple of 6 so every beat starts at puncture-pattern phase 0.
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  2*WIDTH  coded pairs; A_i at bit 2i, B_i at bit 2i+1.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high with tvalid.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tuser  input  4  [1:0] rate code (00 1/2, 01 2/3, 10 3/4, 11 treated as 1/2); [3:2] passed through.
- m_axis_tdata  output  2*WIDTH  packed punctured bits, LSB first.
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final word of frame.
- m_axis_tuser  output  4  tuser latched from first beat of frame.

## Operation
- Rate and tuser latched on first accepted beat of each frame; held until that frame's tlast beat accepted.
- Keep patterns per pair index i: 1/2 keep all; 2/3 period 2: keep A0 B0 A1, drop B1; 3/4 period 3: keep A0 B0 A1 B2, drop B1 A2.
- Kept bits per beat K: 2*WIDTH, 3*WIDTH/2, 4*WIDTH/3 (48/36/32 at WIDTH=24); order preserved, lowest index first.
- Accumulator: 4*WIDTH-bit buffer plus bit count C; new K bits appended at bit position C; unused bits held zero.
- Pop: word = buffer[2*WIDTH-1:0]; buffer shifts down 2*WIDTH; C -= 2*WIDTH (final word: C -> 0).
- m_axis_tvalid = C >= 2*WIDTH, or (flush and C > 0).
- flush set when tlast beat accepted; final word is the pop with flush set and C <= 2*WIDTH after that beat's bits are appended; it carries m_axis_tlast=1, zero-padded above C; flush and C clear on it.
- Frame output words = ceil(beats*K / (2*WIDTH)).
- s_axis_tready = aresetn and !flush and (C - (pop ? 2*WIDTH : 0)) < 2*WIDTH; combinational from m_axis_tready; guarantees no overflow.
- Simultaneous push and pop in one cycle: C_next = C - 2*WIDTH + K.
- Next frame input blocked until final word of current frame pops.

## Timing
- Reset (async assert): m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, C 0, flush 0; s_axis_tready 0 while aresetn low.
- Reset mid-frame: buffered bits and frame discarded; first beat after release starts a new frame.
- Latency: beat accepted at edge t -> dependent output word valid after edge t (visible cycle t+1).
- Throughput: one input beat per cycle at all rates with m_axis_tready held high.
- Output stable (tdata/tlast/tuser) while tvalid high and tready low.

## Configuration
- PUNCTURER_R34_EN defined: rate code 10 selects 3/4.
- Undefined: 3/4 logic omitted; rate code 10 treated as 1/2 (all bits kept).

## Test plan
- Rate 1/2, 4 beats, tready=1 -> 4 words identical to input, back-to-back, tlast on 4th, tready never drops.
- Rate 2/3, 4 beats of 48'hFFFF_FFFF_FFFF -> 3 words of 48'hFFFF_FFFF_FFFF, tlast on 3rd.
- Rate 3/4 (PUNCTURER_R34_EN), single beat 48'hFFFF_FFFF_FFFF -> one word 48'h0000_FFFF_FFFF, tlast=1.
- Rate 3/4 pattern: single beat 48'h18 -> word 0; single beat 48'h20 -> word 48'h8.
- Rate 2/3, 8 beats random data, m_axis_tready toggling 1,0 each cycle -> 6 words match golden model, no loss/duplication, outputs stable while stalled.
- tuser=4'b1111 frame of 2 beats -> treated as 1/2, m_axis_tuser=4'b1111; aresetn pulsed after beat 1 of next frame -> outputs zero, following frame correct.

Source files
------------

// File: rtl/puncturer_if.sv
// AXI-Stream style bundle shared by the puncturer's input and output ports.
// The master drives data/valid/last/user; the slave drives ready.
interface puncturer_if #(
  parameter int DW = 48,
  parameter int UW = 4
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [UW-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/puncturer.sv
// Punctures rate-1/2 coded beats down to 1/2, 2/3 or 3/4 and repacks survivors into 2*WIDTH-bit words.
// Define PUNCTURER_R34_EN to enable the 3/4 rate; otherwise rate code 10 keeps all bits.
//
// state    | meaning
// ST_IDLE  | no frame open; next accepted beat latches rate/tuser
// ST_FRAME | frame open, rate latched, waiting for the tlast beat
// ST_FLUSH | tlast accepted; input blocked until the final word pops
module puncturer #(
  parameter int WIDTH = 24
) (
  input  logic         aclk,
  input  logic         aresetn,
  puncturer_if.slave   s_axis,
  puncturer_if.master  m_axis
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned BW = 4 * WIDTH;
  localparam int unsigned CW = $clog2(BW + 1);
  localparam logic [CW-1:0] C_WORD = CW'(W2);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_FLUSH} state_e;
  typedef enum logic [1:0] {RATE_12, RATE_23, RATE_34} rate_e;

  state_e          state_q, state_d;
  rate_e           rate_q, rate_d;
  logic [3:0]      tuser_q, tuser_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  rate_e           rate_in;
  rate_e           rate_eff;
  logic [W2-1:0]   kept;
  logic [CW-1:0]   kept_n;
  logic            flush;
  logic            out_valid;
  logic            final_word;
  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_base;
  logic [BW-1:0]   buf_base;

  function automatic rate_e decode_rate(input logic [1:0] code);
    rate_e r;
    case (code)
      2'b01:   r = RATE_23;
`ifdef PUNCTURER_R34_EN
      2'b10:   r = RATE_34;
`endif
      default: r = RATE_12;
    endcase
    return r;
  endfunction

  assign rate_in  = decode_rate(s_axis.tuser[1:0]);
  assign rate_eff = (state_q == ST_IDLE) ? rate_in : rate_q;

  // WIDTH is a multiple of 6, so every beat starts at phase 0 of both patterns.
  always_comb begin
    kept   = '0;
    kept_n = C_WORD;
    case (rate_eff)
      RATE_23: begin
        for (int j = 0; j < WIDTH / 2; j++) begin
          kept[3*j +: 3] = s_axis.tdata[4*j +: 3];
        end
        kept_n = CW'(3 * WIDTH / 2);
      end
`ifdef PUNCTURER_R34_EN
      RATE_34: begin
        for (int j = 0; j < WIDTH / 3; j++) begin
          kept[4*j +: 3] = s_axis.tdata[6*j +: 3];
          kept[4*j + 3]  = s_axis.tdata[6*j + 5];
        end
        kept_n = CW'(4 * WIDTH / 3);
      end
`endif
      default: begin
        kept   = s_axis.tdata;
        kept_n = C_WORD;
      end
    endcase
  end

  assign flush      = (state_q == ST_FLUSH);
  assign out_valid  = (cnt_q >= C_WORD) || (flush && (cnt_q != '0));
  assign final_word = flush && (cnt_q <= C_WORD);
  assign pop        = out_valid && m_axis.tready;

  always_comb begin
    cnt_base = cnt_q;
    buf_base = buf_q;
    if (pop) begin
      if (final_word) begin
        cnt_base = '0;
        buf_base = '0;
      end else begin
        cnt_base = cnt_q - C_WORD;
        buf_base = buf_q >> W2;
      end
    end
  end

  // Room for a full beat is guaranteed because cnt_base < W2 before the append.
  assign s_axis.tready = aresetn && !flush && (cnt_base < C_WORD);
  assign push          = s_axis.tvalid && s_axis.tready;

  always_comb begin
    buf_d = buf_base;
    cnt_d = cnt_base;
    if (push) begin
      buf_d = buf_base | ({{W2{1'b0}}, kept} << cnt_base);
      cnt_d = cnt_base + kept_n;
    end
  end

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    tuser_d = tuser_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          rate_d  = rate_in;
          tuser_d = s_axis.tuser;
          state_d = s_axis.tlast ? ST_FLUSH : ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (push && s_axis.tlast) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pop && final_word) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      rate_q  <= RATE_12;
      tuser_q <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      tuser_q <= tuser_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_axis.tdata  = buf_q[W2-1:0];
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_valid && final_word;
  assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_puncturer.sv
// Self-checking bench for puncturer: single-beat vector table plus model-driven multi-beat frames.
module tb_puncturer;
  localparam int WIDTH = 24;
  localparam int W2    = 2 * WIDTH;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  puncturer_if #(.DW(W2), .UW(4)) s_if ();
  puncturer_if #(.DW(W2), .UW(4)) m_if ();

  puncturer #(.WIDTH(WIDTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W2-1:0] data;
    logic          last;
    logic [3:0]    user;
  } word_t;

  typedef struct {
    logic [3:0]    user;
    logic [W2-1:0] data;
    logic [W2-1:0] exp;
  } vec_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  bit         mbits[$];
  bit         mdl_in_frame = 1'b0;
  logic [1:0] mdl_rate = 2'd0;
  logic [3:0] mdl_user = 4'd0;

  bit tog_en = 1'b0;
  bit rdy_val = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] eff_rate(input logic [1:0] code);
    if (code == 2'b01) return 2'd1;
`ifdef PUNCTURER_R34_EN
    if (code == 2'b10) return 2'd2;
`endif
    return 2'd0;
  endfunction

  task automatic emit(input bit last);
    word_t w;
    w.data = '0;
    for (int k = 0; k < W2; k++) begin
      if (mbits.size() > 0) w.data[k] = mbits.pop_front();
    end
    w.last = last;
    w.user = mdl_user;
    exp_q.push_back(w);
  endtask

  // Bit-serial reference: walk the coded pairs and keep per pattern phase.
  task automatic model_push(input logic [W2-1:0] d, input logic [3:0] u, input logic l);
    bit keep_a, keep_b;
    if (!mdl_in_frame) begin
      mdl_rate = eff_rate(u[1:0]);
      mdl_user = u;
    end
    mdl_in_frame = !l;
    for (int i = 0; i < WIDTH; i++) begin
      case (mdl_rate)
        2'd1:    begin keep_a = 1'b1;       keep_b = (i % 2 == 0); end
        2'd2:    begin keep_a = (i % 3 != 2); keep_b = (i % 3 != 1); end
        default: begin keep_a = 1'b1;       keep_b = 1'b1; end
      endcase
      if (keep_a) mbits.push_back(d[2*i]);
      if (keep_b) mbits.push_back(d[2*i+1]);
    end
    while (mbits.size() > W2 || (!l && mbits.size() == W2)) emit(1'b0);
    if (l) emit(1'b1);
  endtask

  // Starts at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [W2-1:0] d, input logic [3:0] u, input logic l,
                           input bit use_model, output int waits);
    waits = 0;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_if.tready) break;
      waits++;
      if (waits > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no s_axis_tready, expected acceptance within 300 cycles");
        break;
      end
    end
    @(posedge aclk);
    if (use_model) model_push(d, u, l);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge aclk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  always @(posedge aclk) begin
    #1;
    if (tog_en) m_if.tready = ~m_if.tready;
    else        m_if.tready = rdy_val;
  end

  word_t held;
  word_t mon_e;
  bit    stall_pend = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid_held", 64'(m_if.tvalid), 64'd1);
        check("stall_data_stable", 64'(m_if.tdata), 64'(held.data));
        check("stall_last_stable", 64'(m_if.tlast), 64'(held.last));
        check("stall_user_stable", 64'(m_if.tuser), 64'(held.user));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", m_if.tdata, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(m_if.tdata), 64'(mon_e.data));
          check("out_last", 64'(m_if.tlast), 64'(mon_e.last));
          check("out_user", 64'(m_if.tuser), 64'(mon_e.user));
        end
      end
      stall_pend = m_if.tvalid && !m_if.tready;
      held.data  = m_if.tdata;
      held.last  = m_if.tlast;
      held.user  = m_if.tuser;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt[11];
    word_t      w;
    int         waits;
    int         total_waits;
    logic [3:0] u;

    vt[0]  = '{4'b0100, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
    vt[1]  = '{4'b0001, 48'hFFFF_FFFF_FFFF, 48'h000F_FFFF_FFFF};
    vt[2]  = '{4'b0001, 48'h0000_0000_0008, 48'h0};
    vt[3]  = '{4'b0001, 48'h0000_0000_0004, 48'h4};
    vt[4]  = '{4'b0001, 48'h0000_0000_0030, 48'h18};
    vt[5]  = '{4'b1111, 48'hA5A5_0F0F_3C3C, 48'hA5A5_0F0F_3C3C};
    vt[10] = '{4'b0101, 48'h8000_0000_0000, 48'h0};
`ifdef PUNCTURER_R34_EN
    vt[6]  = '{4'b0010, 48'hFFFF_FFFF_FFFF, 48'h0000_FFFF_FFFF};
    vt[7]  = '{4'b0010, 48'h0000_0000_0018, 48'h0};
    vt[8]  = '{4'b0010, 48'h0000_0000_0020, 48'h8};
    vt[9]  = '{4'b1110, 48'h8000_0000_0000, 48'h0000_8000_0000};
`else
    vt[6]  = '{4'b0010, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    vt[7]  = '{4'b0010, 48'h0000_0000_0018, 48'h18};
    vt[8]  = '{4'b0010, 48'h0000_0000_0020, 48'h20};
    vt[9]  = '{4'b1110, 48'h8000_0000_0000, 48'h8000_0000_0000};
`endif

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    aresetn     = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("rst_m_tuser", 64'(m_if.tuser), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single-beat frames: each yields exactly one final word.
    for (int i = 0; i < 11; i++) begin
      w.data = vt[i].exp;
      w.last = 1'b1;
      w.user = vt[i].user;
      exp_q.push_back(w);
      send_beat(vt[i].data, vt[i].user, 1'b1, 1'b0, waits);
    end
    drain();

    // Rate 1/2, 4 beats, no input stall expected.
    total_waits = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat({$urandom(), 16'($urandom())}, 4'b0000, (i == 3), 1'b1, waits);
      total_waits += waits;
    end
    check("r12_tready_never_dropped", 64'(total_waits), 64'd0);
    drain();

    // Rate 2/3, 4 all-ones beats; later tuser values must be ignored.
    for (int i = 0; i < 4; i++) begin
      u = (i == 0) ? 4'b1001 : 4'($urandom());
      send_beat(48'hFFFF_FFFF_FFFF, u, (i == 3), 1'b1, waits);
    end
    drain();

    // Rate 2/3, 8 random beats with output ready toggling.
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      u = (i == 0) ? {2'($urandom()), 2'b01} : 4'($urandom());
      send_beat({$urandom(), 16'($urandom())}, u, (i == 7), 1'b1, waits);
    end
    drain();
    tog_en = 1'b0;

    // Rate code 10, 5 random beats: partial final word.
    for (int i = 0; i < 5; i++) begin
      send_beat({$urandom(), 16'($urandom())}, 4'b0110, (i == 4), 1'b1, waits);
    end
    drain();

    // tuser 1111 frame, then reset in the middle of the next frame.
    for (int i = 0; i < 2; i++) begin
      send_beat({$urandom(), 16'($urandom())}, 4'b1111, (i == 1), 1'b1, waits);
    end
    drain();
    send_beat({$urandom(), 16'($urandom())}, 4'b0101, 1'b0, 1'b1, waits);
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("midrst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("midrst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("midrst_m_tuser", 64'(m_if.tuser), 64'd0);
    check("midrst_s_tready", 64'(s_if.tready), 64'd0);
    exp_q.delete();
    mbits.delete();
    mdl_in_frame = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send_beat({$urandom(), 16'($urandom())}, 4'b1000, (i == 2), 1'b1, waits);
    end
    drain();

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
